// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the seven-segment scroll controller.
//   - SEG_A..SEG_G, SEG_DP : bit masks of one segment pattern (1 = lit)
//   - BLANK                : pattern with every segment dark
//   - DIGITS               : number of digits in the display window
//   - state_t              : controller FSM encoding (2 bits)
//   - shift_in()           : shifts one pattern into the right end of the window
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [7:0] SEG_A  = 8'h01;
    localparam logic [7:0] SEG_B  = 8'h02;
    localparam logic [7:0] SEG_C  = 8'h04;
    localparam logic [7:0] SEG_D  = 8'h08;
    localparam logic [7:0] SEG_E  = 8'h10;
    localparam logic [7:0] SEG_F  = 8'h20;
    localparam logic [7:0] SEG_G  = 8'h40;
    localparam logic [7:0] SEG_DP = 8'h80;
    localparam logic [7:0] BLANK  = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // The window scrolls right-to-left: the old leftmost digit falls off and
    // the new pattern enters as the rightmost digit.
    function automatic logic [31:0] shift_in(input logic [31:0] win,
                                             input logic [7:0]  pat);
        return {win[23:0], pat};
    endfunction

endpackage

// File: rtl/seg7_scroll_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scroll_ctrl_if
// CPU-side interface of the seven-segment scroll controller.
//   wr_en/wr_data/wr_ready : pattern write handshake
//   start/abort            : single-cycle command pulses
//   mode/hex_val           : display mode select and hex value
//   busy/done              : status
// Modports: master = CPU peripheral side, slave = controller side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface seg7_scroll_ctrl_if;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        start;
    logic        abort;
    logic        mode;
    logic [15:0] hex_val;
    logic        busy;
    logic        done;

    modport master (
        output wr_en, wr_data, start, abort, mode, hex_val,
        input  wr_ready, busy, done
    );

    modport slave (
        input  wr_en, wr_data, start, abort, mode, hex_val,
        output wr_ready, busy, done
    );
endinterface

// File: rtl/seg7_pat_fifo.sv
// -----------------------------------------------------------------------------
// seg7_pat_fifo
// DEPTH x 8 segment-pattern buffer with read/write pointers and an occupancy
// count. The head of a message can be marked and later restored so that the
// same message can be replayed without being rewritten.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write one pattern (caller guarantees not full)
//   pop             : advance the read pointer (caller guarantees not empty)
//   flush           : empty the buffer, pointers and count to 0
//   mark            : remember the current read pointer as message head
//   restore         : rewind the read pointer to the head, count <= restore_cnt
//   rd_data         : pattern at the read pointer
//   count/full/empty: occupancy status
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seg7_pat_fifo
    import seg7_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    input  logic          mark,
    input  logic          restore,
    input  logic [CW-1:0] restore_cnt,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] head_q,   head_d;
    logic [CW-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            head_d   = '0;
            count_d  = '0;
        end else begin
            if (mark) begin
                head_d = rd_ptr_q;
            end
            if (restore) begin
                // Replay: storage was never overwritten, only the read side rewinds.
                rd_ptr_d = head_q;
                count_d  = restore_cnt;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            count_q  <= count_d;
        end
    end

    // Pattern storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scroll_ctrl
// Sequencer in front of the 4-digit seven-segment driver. Buffers a message of
// raw segment patterns and scrolls it right-to-left across the display, one
// digit every 2^STEP clocks, followed by DIGITS blanks. Hex mode is a straight
// registered pass-through of hex_val/mode to the driver.
// Parameters: DEPTH (buffer entries, power of 2, 4..64), STEP (log2 step period)
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : CPU-side interface (slave modport)
//   loop        : replay the message endlessly (only with SEG7_SCROLL_LOOP_EN)
//   di          : registered hex_val to the driver
//   pixels      : display window, [31:24] leftmost digit, [7:0] rightmost digit
//   direct      : registered mode to the driver
// Build option: define SEG7_SCROLL_LOOP_EN to add the loop input and message
// replay; without it every message scrolls out once and pulses done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seg7_scroll_ctrl
    import seg7_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int STEP  = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scroll_ctrl_if.slave    bus,
`ifdef SEG7_SCROLL_LOOP_EN
    input  logic                 loop,
`endif
    output logic [15:0]          di,
    output logic [31:0]          pixels,
    output logic                 direct
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_q, state_d;
    logic [STEP-1:0] presc_q, presc_d;
    logic [31:0]     window_q, window_d;
    logic [2:0]      drain_q, drain_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [15:0]     di_q, di_d;
    logic            direct_q, direct_d;

    logic            tick;
    logic            loop_now;
    logic            fifo_push, fifo_pop, fifo_flush, fifo_mark, fifo_restore;
    logic [7:0]      fifo_rd_data;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   fifo_restore_cnt;
    logic            fifo_full, fifo_empty;

`ifdef SEG7_SCROLL_LOOP_EN
    logic [CW-1:0]   msg_len_q, msg_len_d;

    // Message length includes a pattern written in the same cycle as start,
    // since that pattern is part of the first pass as well.
    always_comb begin
        msg_len_d = msg_len_q;
        if (fifo_mark) begin
            msg_len_d = fifo_count + CW'(fifo_push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) msg_len_q <= '0;
        else       msg_len_q <= msg_len_d;
    end

    assign loop_now         = loop;
    assign fifo_restore_cnt = msg_len_q;
`else
    assign loop_now         = 1'b0;
    assign fifo_restore_cnt = '0;
`endif

    seg7_pat_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_data   (bus.wr_data),
        .pop         (fifo_pop),
        .flush       (fifo_flush),
        .mark        (fifo_mark),
        .restore     (fifo_restore),
        .restore_cnt (fifo_restore_cnt),
        .rd_data     (fifo_rd_data),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign tick         = &presc_q;
    assign bus.wr_ready = (state_q == IDLE) && !fifo_full && !reset;

    always_comb begin
        state_d      = state_q;
        presc_d      = (state_q == IDLE) ? '0 : presc_q + 1'b1;
        window_d     = window_q;
        drain_d      = drain_q;
        done_d       = 1'b0;
        di_d         = bus.hex_val;
        direct_d     = bus.mode;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        fifo_mark    = 1'b0;
        fifo_restore = 1'b0;
        // abort wins over a simultaneous write: the flushed buffer stays empty.
        fifo_push    = bus.wr_en && bus.wr_ready && !bus.abort;

        unique case (state_q)
            IDLE: begin
                if (bus.abort) begin
                    fifo_flush = 1'b1;
                    window_d   = {DIGITS{BLANK}};
                end else if (bus.start && !fifo_empty) begin
                    state_d   = SCROLL;
                    presc_d   = '0;
                    fifo_mark = 1'b1;
                end
            end
            SCROLL: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    fifo_flush = 1'b1;
                    window_d   = {DIGITS{BLANK}};
                end else if (tick) begin
                    window_d = shift_in(window_q, fifo_rd_data);
                    fifo_pop = 1'b1;
                    if (fifo_count == CW'(1)) begin
                        state_d = DRAIN;
                        drain_d = 3'(DIGITS);
                    end
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    fifo_flush = 1'b1;
                    window_d   = {DIGITS{BLANK}};
                end else if (tick) begin
                    window_d = shift_in(window_q, BLANK);
                    drain_d  = drain_q - 1'b1;
                    if (drain_q == 3'd1) begin
                        if (loop_now) begin
                            fifo_restore = 1'b1;
                            state_d      = SCROLL;
                            presc_d      = '0;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy is registered from the next state so it falls on the same edge
        // that raises done.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            window_q <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            di_q     <= '0;
            direct_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            window_q <= window_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            di_q     <= di_d;
            direct_q <= direct_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign di       = di_q;
    assign pixels   = window_q;
    assign direct   = direct_q;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
`timescale 1ns/1ps
module tb_seg7_scroll_ctrl;
    localparam int DEPTH = 16;
    localparam int STEP  = 3;
    localparam int PER   = 8;   // 2^STEP cycles per shift

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scroll_ctrl_if bus();
    logic [15:0] di;
    logic [31:0] pixels;
    logic        direct;
    logic        loop_v = 1'b0;

    seg7_scroll_ctrl #(.DEPTH(DEPTH), .STEP(STEP)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
`ifdef SEG7_SCROLL_LOOP_EN
        .loop   (loop_v),
`endif
        .di     (di),
        .pixels (pixels),
        .direct (direct)
    );

    int total = 0;
    int bad   = 0;
    int seen_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (message queue + step timing) ---------
    logic [7:0]  q[$];
    logic [7:0]  m_msg[$];
    int          m_phase = 0;   // 0 idle, 1 shifting message, 2 shifting blanks
    int          m_cyc = 0;
    int          m_blanks = 0;
    logic [31:0] m_win = '0;
    logic        m_done = 1'b0;
    logic [15:0] m_di = '0;
    logic        m_dir = 1'b0;

    function automatic logic exp_ready();
        return (m_phase == 0) && (q.size() < DEPTH) && !reset;
    endfunction

    task automatic model_update();
        bit had;
        if (reset) begin
            q.delete(); m_phase = 0; m_cyc = 0; m_blanks = 0;
            m_win = '0; m_done = 1'b0; m_di = '0; m_dir = 1'b0;
        end else begin
            had    = (q.size() > 0);
            m_di   = bus.hex_val;
            m_dir  = bus.mode;
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (bus.abort) begin
                    q.delete(); m_win = '0;
                end else begin
                    if (bus.wr_en && q.size() < DEPTH) q.push_back(bus.wr_data);
                    if (bus.start && had) begin
                        m_phase = 1; m_cyc = 0; m_msg = q;
                    end
                end
            end else if (bus.abort) begin
                q.delete(); m_win = '0; m_phase = 0;
            end else begin
                m_cyc++;
                if (m_cyc == PER) begin
                    m_cyc = 0;
                    if (m_phase == 1) begin
                        m_win = {m_win[23:0], q.pop_front()};
                        if (q.size() == 0) begin m_phase = 2; m_blanks = 4; end
                    end else begin
                        m_win = m_win << 8;
                        m_blanks--;
                        if (m_blanks == 0) begin
                            if (loop_v) begin q = m_msg; m_phase = 1; end
                            else begin m_phase = 0; m_done = 1'b1; end
                        end
                    end
                end
            end
        end
    endtask

    // One clock: check wr_ready mid-cycle, advance model, compare after edge.
    task automatic step();
        @(negedge clk);
        check("wr_ready", bus.wr_ready, exp_ready());
        model_update();
        @(posedge clk);
        #1;
        check("m_pixels", pixels, m_win);
        check("m_busy", bus.busy, m_phase != 0);
        check("m_done", bus.done, m_done);
        check("m_di", di, m_di);
        check("m_direct", direct, m_dir);
        if (bus.done) seen_done++;
    endtask

    task automatic clear_pulses();
        bus.wr_en = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic write_pat(input logic [7:0] p);
        bus.wr_en = 1'b1; bus.wr_data = p;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_data;
        logic        start;
        logic        mode;
        logic [15:0] hex;
        int          n;
        logic [31:0] pix;
        logic        busy;
        logic        done;
        logic [15:0] di;
        logic        dir;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tbl[0] = '{1'b1, 8'h06, 1'b0, 1'b0, 16'hBEEF, 1, 32'h00000000, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[1] = '{1'b1, 8'h5B, 1'b0, 1'b0, 16'hBEEF, 1, 32'h00000000, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hBEEF, 9, 32'h00000006, 1'b1, 1'b0, 16'hBEEF, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hBEEF, 8, 32'h0000065B, 1'b1, 1'b0, 16'hBEEF, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hBEEF, 8, 32'h00065B00, 1'b1, 1'b0, 16'hBEEF, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 8, 32'h065B0000, 1'b1, 1'b0, 16'h1234, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 8, 32'h5B000000, 1'b1, 1'b0, 16'h1234, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 7, 32'h5B000000, 1'b1, 1'b0, 16'h1234, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1, 32'h00000000, 1'b0, 1'b1, 16'h1234, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1, 32'h00000000, 1'b0, 1'b0, 16'h1234, 1'b0};

        // Reset held 3 cycles, then released
        reset = 1'b1; clear_pulses(); bus.wr_data = '0; bus.mode = 1'b0; bus.hex_val = '0;
        repeat (3) step();
        reset = 1'b0;
        #2;
        check("rst_wr_ready", bus.wr_ready, 1'b1);
        check("rst_pixels", pixels, 32'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_di", di, 16'h0);
        check("rst_direct", direct, 1'b0);

        // Two-pattern scroll, hex pass-through, mode toggle mid-scroll
        for (int i = 0; i < 10; i++) begin
            bus.wr_en = tbl[i].wr_en; bus.wr_data = tbl[i].wr_data;
            bus.start = tbl[i].start; bus.mode = tbl[i].mode; bus.hex_val = tbl[i].hex;
            step();
            clear_pulses();
            repeat (tbl[i].n - 1) step();
            check($sformatf("row%0d_pixels", i), pixels, tbl[i].pix);
            check($sformatf("row%0d_busy", i), bus.busy, tbl[i].busy);
            check($sformatf("row%0d_done", i), bus.done, tbl[i].done);
            check($sformatf("row%0d_di", i), di, tbl[i].di);
            check($sformatf("row%0d_direct", i), direct, tbl[i].dir);
        end

        // Fill to DEPTH, 17th write dropped, then 16 patterns + 4 blanks
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i + 1);
            #2;
            check($sformatf("fill%0d_wr_ready", i), bus.wr_ready, (i < DEPTH));
            step();
        end
        clear_pulses();
        pulse_start();
        cnt = 0;
        while (!bus.done && cnt < 400) begin
            step();
            cnt++;
            if (cnt == 16 * PER) check("full_last_window", pixels, 32'h0D0E0F10);
        end
        check("full_done_cycle", cnt, 20 * PER);
        check("full_end_pixels", pixels, 32'h0);

        // Abort in the 2nd step period, then start on empty buffer
        for (int i = 0; i < 4; i++) write_pat(8'hA0 + 8'(i));
        pulse_start();
        repeat (10) step();
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_pixels", pixels, 32'h0);
        check("abort_done", bus.done, 1'b0);
        check("abort_wr_ready", bus.wr_ready, 1'b1);
        seen_done = 0;
        pulse_start();
        check("empty_start_busy", bus.busy, 1'b0);
        repeat (20) step();
        check("empty_start_no_done", seen_done, 0);

        // abort beats start in the same cycle
        write_pat(8'h3F);
        bus.start = 1'b1; bus.abort = 1'b1; step(); clear_pulses();
        check("abort_vs_start_busy", bus.busy, 1'b0);
        pulse_start();
        check("flushed_start_busy", bus.busy, 1'b0);

        // Reset mid-scroll
        write_pat(8'h77); write_pat(8'h7C);
        pulse_start();
        repeat (12) step();
        check("mid_scroll_pixels", pixels, 32'h00000077);
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_mid_pixels", pixels, 32'h0);
        check("reset_mid_busy", bus.busy, 1'b0);

`ifdef SEG7_SCROLL_LOOP_EN
        // Loop replay: repeats with no done, then ends after dropping loop
        write_pat(8'h06); write_pat(8'h5B);
        loop_v = 1'b1;
        pulse_start();
        seen_done = 0;
        cnt = 0;
        while (cnt < 144) begin
            step();
            cnt++;
            if (cnt == 56)  check("loop_pass2_a", pixels, 32'h00000006);
            if (cnt == 64)  check("loop_pass2_b", pixels, 32'h0000065B);
            if (cnt == 96)  check("loop_pass2_end_busy", bus.busy, 1'b1);
            if (cnt == 104) check("loop_pass3_a", pixels, 32'h00000006);
            if (cnt == 112) begin check("loop_pass3_b", pixels, 32'h0000065B); loop_v = 1'b0; end
            if (cnt == 143) check("loop_no_done", seen_done, 0);
        end
        check("loop_final_done", bus.done, 1'b1);
        check("loop_final_busy", bus.busy, 1'b0);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            bus.wr_en   = ($urandom % 2) == 0;
            bus.wr_data = 8'($urandom);
            bus.start   = ($urandom % 16) == 0;
            bus.abort   = ($urandom % 200) == 0;
            if (($urandom % 50) == 0) bus.mode = ~bus.mode;
            bus.hex_val = 16'($urandom);
            reset       = ($urandom % 700) == 0;
            step();
        end
        reset = 1'b0;
        clear_pulses();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scroll_ctrl.md
Name: seg7_scroll_ctrl

Overview:
- Sequencer that sits in front of the 4-digit seven-segment driver and owns the driver's `di`, `pixels` and `direct` inputs.
- Accepts a message of raw segment patterns into an internal buffer, then scrolls it right-to-left across the 4 digits at a fixed step rate.
- Alternatively passes a 16-bit hex value straight through in hex mode.
- Gives the CPU-side peripheral a simple write/start/abort interface with busy/done status.

Parameters:
- DEPTH, 16: pattern buffer entries; must be a power of 2, range 4..64.
- STEP, 22: step period is 2^STEP clk cycles per one-digit scroll shift.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  push `wr_data` into the buffer
- wr_data  in  8  segment pattern; bit0=A … bit6=G, bit7=DP; 1 = lit
- wr_ready  out  1  write accepted this cycle if `wr_en` is high
- start  in  1  single-cycle pulse; begin scrolling the buffered message
- abort  in  1  single-cycle pulse; stop, flush buffer, blank window
- mode  in  1  0 = hex display of `hex_val`, 1 = direct pattern display
- hex_val  in  16  value shown in hex mode
- busy  out  1  high when the state is not IDLE
- done  out  1  one-cycle pulse when a message has fully scrolled out
- di  out  16  to display driver; registered copy of `hex_val`
- pixels  out  32  to display driver; [31:24] = leftmost digit, [7:0] = rightmost digit
- direct  out  1  to display driver; registered copy of `mode`

Behaviour:
- Reset values: state IDLE; window, pixels, di = 0; direct, busy, done = 0; buffer count and pointers = 0; wr_ready = 0 while reset is asserted.
- All outputs are registered. `di`/`direct` follow `hex_val`/`mode` with 1-cycle latency in every state.
- Buffer:
  - FIFO with read pointer, write pointer and count (width clog2(DEPTH)+1).
  - wr_ready = (state==IDLE) && (count<DEPTH) && !reset.
  - A write when not ready is dropped, with no side effect.
- Step tick:
  - Prescaler is cleared on every transition into SCROLL.
  - tick asserts for 1 cycle when the prescaler reaches 2^STEP−1, then the prescaler wraps to 0.
  - The first shift occurs exactly 2^STEP cycles after the cycle in which `start` is sampled.
- FSM:
  - IDLE:
    - abort → flush buffer (count and pointers = 0) and set window = 0.
    - Otherwise start && count>0 → SCROLL.
    - start with count==0 is ignored; no done pulse.
  - SCROLL: on tick, window <= {window[23:0], buf[rd_ptr]}; rd_ptr++ (wraps modulo DEPTH); count−−. If this pop makes count 0 → DRAIN with drain_cnt=4.
  - DRAIN: on tick, window <= {window[23:0], 8'h00}; drain_cnt−−. When drain_cnt reaches 0 → IDLE and pulse done for 1 cycle.
  - abort in SCROLL or DRAIN → IDLE next cycle: buffer flushed, window=0, no done pulse.
- pixels = window, registered, in every state.
- Priority and boundary cases:
  - abort beats start and tick in the same cycle.
  - start while busy is ignored.
  - mode change mid-scroll only changes `direct`; scrolling continues unaffected.
  - DEPTH writes fill the buffer; the (DEPTH+1)th write is dropped while wr_ready=0.
- Reset asserted mid-SCROLL returns every register to its reset value on the next edge.

Optional Feature:
- Macro: SEG7_SCROLL_LOOP_EN.
- Defined:
  - Adds input port `loop` (1 bit) and register `msg_len`, which latches count at start.
  - At the end of DRAIN with loop=1: restore rd_ptr to the message head, set count=msg_len, re-enter SCROLL with the prescaler cleared, and do not pulse done.
  - The buffer is read non-destructively in this mode; only abort or loop=0 at the end of DRAIN terminates.
- Undefined: no `loop` port; always one-shot behaviour as above.

Decomposition:
- Package seg7_pkg holds:
  - segment bit constants SEG_A..SEG_G and SEG_DP;
  - BLANK = 8'h00;
  - FSM state encoding IDLE/SCROLL/DRAIN (2 bits);
  - DIGITS = 4.
- One natural sub-module: seg7_pat_fifo, containing the DEPTH×8 storage, pointers, count, full/empty, and a head-restore input for the loop feature.
- The FSM, prescaler and window register stay in the top module.

Test Plan (STEP=3 in simulation):
- Reset held 3 cycles, then released → pixels=0, busy=0, done=0, wr_ready=1 on the first cycle after release.
- Write 8'h06, 8'h5B, then start → pixels: 0x00000006 at +8 cycles, 0x0000065B at +16, then 0x00065B00, 0x065B0000, 0x5B000000, 0x00000000. done pulses 1 cycle with the last shift; busy falls on the same edge.
- Write 17 patterns with DEPTH=16 → the 17th write is seen with wr_ready=0 and dropped. After start, exactly 16 patterns plus 4 blanks shift out.
- Start a 4-pattern message, assert abort during the 2nd step period → IDLE next cycle, pixels=0, count=0, no done pulse. A following start is ignored because the buffer is empty.
- mode=0, hex_val=16'hBEEF → di=16'hBEEF, direct=0 one cycle later. Toggle mode=1 mid-scroll → direct=1 next cycle and the shift sequence is unchanged.
- With SEG7_SCROLL_LOOP_EN and loop=1, 2-pattern message → the sequence repeats after 4 blanks at least twice with no done pulse. Drop loop → done after the next drain.
